inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 11 +
 rtl/inst_queue_if.sv | 29 ++
 rtl/inst_queue.sv | 56 +++++
 tb/tb_inst_queue.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: default sizes and entry type shared by the instruction queue and its users
package inst_queue_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W = 8;
  localparam int PTR_W = $clog2(DEF_DEPTH);
  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_PC_W-1:0] pc;
  } iq_entry_t;
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side push, decode-side show-ahead pop and occupancy of the instruction queue
interface inst_queue_if import inst_queue_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int INST_W = DEF_INST_W,
  parameter int PC_W = DEF_PC_W
);
  logic flush;
  logic in_valid;
  logic [INST_W-1:0] in_inst1;
  logic [INST_W-1:0] in_inst2;
  logic [PC_W-1:0] in_pc;
  logic in_ready;
  logic out_valid0;
  logic out_valid1;
  logic [INST_W-1:0] out_inst0;
  logic [INST_W-1:0] out_inst1;
  logic [PC_W-1:0] out_pc0;
  logic [PC_W-1:0] out_pc1;
  logic [1:0] deq_cnt;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, in_valid, in_inst1, in_inst2, in_pc, deq_cnt,
    input in_ready, out_valid0, out_valid1, out_inst0, out_inst1, out_pc0, out_pc1, count
  );
  modport slave (
    input flush, in_valid, in_inst1, in_inst2, in_pc, deq_cnt,
    output in_ready, out_valid0, out_valid1, out_inst0, out_inst1, out_pc0, out_pc1, count
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: circular buffer taking fetch pairs and presenting the two oldest instructions to decode
module inst_queue import inst_queue_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int INST_W = DEF_INST_W,
  parameter int PC_W = DEF_PC_W
) (
  input logic clk,
  input logic rst_n,
  inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0] pc;
  } entry_t;
  entry_t mem [DEPTH];
  logic [AW-1:0] head, tail, head1;
  logic [CW-1:0] count;
  logic [1:0] dq, pop;
  logic push;
  // pop is clamped to occupancy so a greedy decode can never underflow
  always_comb begin
    dq = q.deq_cnt[1] ? 2'd2 : q.deq_cnt;
    pop = (CW'(dq) > count) ? count[1:0] : dq;
    push = q.in_valid && q.in_ready && !q.flush;
    head1 = head + AW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= push ? tail + AW'(2) : tail;
      count <= count + (push ? CW'(2) : CW'(0)) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem[tail] <= '{q.in_inst1, q.in_pc};
      mem[tail + AW'(1)] <= '{q.in_inst2, q.in_pc + PC_W'(4)};
    end
  assign q.count = count;
  assign q.in_ready = count <= CW'(DEPTH - 2);
  assign q.out_valid0 = count != '0;
  assign q.out_valid1 = count >= CW'(2);
  assign q.out_inst0 = q.out_valid0 ? mem[head].inst : '0;
  assign q.out_pc0 = q.out_valid0 ? mem[head].pc : '0;
  assign q.out_inst1 = q.out_valid1 ? mem[head1].inst : '0;
  assign q.out_pc1 = q.out_valid1 ? mem[head1].pc : '0;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: random and directed stimulus against a queue-of-entries model with a scoreboard monitor
module tb_inst_queue;
  import inst_queue_pkg::*;
  localparam int DEPTH = DEF_DEPTH;
  typedef struct {
    int cnt;
    bit v0, v1, rdy;
    logic [31:0] i0, i1;
    logic [7:0] p0, p1;
  } snap_t;
  logic clk = 0;
  logic rst_n = 0;
  int errors = 0, checks = 0;
  iq_entry_t model [$];
  snap_t exp_q [$];
  inst_queue_if #(.DEPTH(DEPTH)) q ();
  inst_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .q(q.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic snap_t snap();
    snap_t s;
    s.cnt = model.size();
    s.v0 = s.cnt >= 1;
    s.v1 = s.cnt >= 2;
    s.rdy = DEPTH - s.cnt >= 2;
    s.i0 = s.v0 ? model[0].inst : '0;
    s.p0 = s.v0 ? model[0].pc : '0;
    s.i1 = s.v1 ? model[1].inst : '0;
    s.p1 = s.v1 ? model[1].pc : '0;
    return s;
  endfunction
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      snap_t e;
      e = exp_q.pop_front();
      chk("count", 32'(q.count), 32'(e.cnt));
      chk("in_ready", 32'(q.in_ready), 32'(e.rdy));
      chk("out_valid0", 32'(q.out_valid0), 32'(e.v0));
      chk("out_valid1", 32'(q.out_valid1), 32'(e.v1));
      chk("out_inst0", q.out_inst0, e.i0);
      chk("out_pc0", 32'(q.out_pc0), 32'(e.p0));
      chk("out_inst1", q.out_inst1, e.i1);
      chk("out_pc1", 32'(q.out_pc1), 32'(e.p1));
    end
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] b,
                     input logic [7:0] pc, input logic [1:0] d, input bit f);
    bit rdy;
    int n;
    q.in_valid = v;
    q.in_inst1 = a;
    q.in_inst2 = b;
    q.in_pc = pc;
    q.deq_cnt = d;
    q.flush = f;
    @(posedge clk);
    if (!rst_n || f) model.delete();
    else begin
      rdy = DEPTH - model.size() >= 2;
      n = (d == 3) ? 2 : int'(d);
      if (n > model.size()) n = model.size();
      repeat (n) void'(model.pop_front());
      if (v && rdy) begin
        model.push_back('{a, pc});
        model.push_back('{b, pc + 8'd4});
      end
    end
    exp_q.push_back(snap());
    #1;
  endtask
  task automatic rnd(input int n, input int flush_pct);
    repeat (n)
      cyc($urandom_range(99) < 70, $urandom, $urandom, 8'($urandom),
          2'($urandom), $urandom_range(99) < flush_pct);
  endtask
  task automatic pulse_reset();
    rst_n = 0;
    exp_q.delete();
    model.delete();
    #1;
    chk("rst_count", 32'(q.count), 0);
    chk("rst_valid0", 32'(q.out_valid0), 0);
    chk("rst_valid1", 32'(q.out_valid1), 0);
    chk("rst_inst0", q.out_inst0, 0);
    chk("rst_pc1", 32'(q.out_pc1), 0);
    chk("rst_ready", 32'(q.in_ready), 1);
    cyc(1, 32'h1, 32'h2, 8'h10, 2'd0, 0);
    rst_n = 1;
  endtask
  initial begin
    q.flush = 0;
    q.in_valid = 0;
    q.in_inst1 = '0;
    q.in_inst2 = '0;
    q.in_pc = '0;
    q.deq_cnt = '0;
    #1;
    chk("init_count", 32'(q.count), 0);
    chk("init_ready", 32'(q.in_ready), 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    cyc(1, 32'h00500093, 32'h00A00113, 8'h00, 2'd0, 0);
    chk("first_pc1", 32'(q.out_pc1), 32'h04);
    for (int i = 1; i < 4; i++)
      cyc(1, 32'h100 + 32'(i), 32'h200 + 32'(i), 8'(8 * i), 2'd0, 0);
    cyc(1, 32'hDEAD, 32'hBEEF, 8'h40, 2'd0, 0);
    chk("full_count", 32'(q.count), 8);
    cyc(0, 0, 0, 0, 2'd1, 0);
    chk("after_pop1_pc0", 32'(q.out_pc0), 32'h04);
    cyc(0, 0, 0, 0, 2'd2, 0);
    cyc(0, 0, 0, 0, 2'd3, 0);
    for (int i = 0; i < 20; i++)
      cyc(1, 32'h3000 + 32'(i), 32'h4000 + 32'(i), 8'hF8 + 8'(8 * i), 2'd2, 0);
    rnd(6, 0);
    while (model.size() < 5) cyc(1, $urandom, $urandom, 8'($urandom), 2'd0, 0);
    while (model.size() > 5) cyc(0, 0, 0, 0, 2'd1, 0);
    cyc(1, 32'h5, 32'h6, 8'h20, 2'd2, 1);
    chk("flush_count", 32'(q.count), 0);
    cyc(1, 32'h7, 32'h8, 8'hFC, 2'd0, 0);
    cyc(0, 0, 0, 0, 2'd1, 0);
    cyc(0, 0, 0, 0, 2'd2, 0);
    cyc(0, 0, 0, 0, 2'd2, 0);
    rnd(40, 3);
    pulse_reset();
    rnd(300, 4);
    rnd(20, 0);
    pulse_reset();
    rnd(100, 2);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
